// File: rtl/uart_tx_fifo.sv
// UART transmitter with write-side FIFO, internal baud divider, 5..9 data bits, 1/2 stop bits; UART_TX_FIFO_PARITY_EN adds an even parity bit.
// Latency: a word pushed into an empty FIFO with the line idle starts its start bit on the next edge.
// Backpressure: tx_rdy drops when the FIFO is full; a write attempted while full is dropped and flagged on overflow.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_vld_i,
  input  logic [W-1:0]           wr_dat_i,
  output logic                   wr_rdy_o,
  input  logic                   rd_rdy_i,
  output logic                   rd_vld_o,
  output logic [W-1:0]           rd_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [$clog2(DEPTH):0] count_nxt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign wr_rdy_o    = (count_q != FULL);
  assign rd_vld_o    = (count_q != '0);
  assign push        = wr_vld_i && wr_rdy_o;
  assign pop         = rd_rdy_i && rd_vld_o;
  assign rd_dat_o    = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + ONE;
    else if (!push && pop)
      count_d = count_q - ONE;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end
endmodule

module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_val,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_rdy,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  localparam int BW = $clog2(STOP_BITS*CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS-1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                    state_q;
  logic [BW-1:0]             baud_q;
  logic [IW-1:0]             bit_idx_q;
  logic [DATA_BITS-1:0]      shift_q;
  logic                      tx_q, busy_q, overflow_q;
`ifdef UART_TX_FIFO_PARITY_EN
  logic                      par_q;
`endif

  logic                      fifo_nonempty, pop, frame_end, idle_d, busy_d;
  logic [DATA_BITS-1:0]      head_dat;
  logic [$clog2(FIFO_DEPTH):0] count_nxt;

  sync_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_vld_i    (tx_val),
    .wr_dat_i    (tx_data),
    .wr_rdy_o    (tx_rdy),
    .rd_rdy_i    (pop),
    .rd_vld_o    (fifo_nonempty),
    .rd_dat_o    (head_dat),
    .count_o     (fifo_count),
    .count_nxt_o (count_nxt)
  );

  // The last stop cycle doubles as the load point so frames run back-to-back.
  assign frame_end = (state_q == S_STOP) && (baud_q == '0);
  assign pop       = fifo_nonempty && ((state_q == S_IDLE) || frame_end);
  assign idle_d    = !pop && ((state_q == S_IDLE) || frame_end);
  assign busy_d    = !idle_d || (count_nxt != '0);

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      busy_q     <= busy_d;
      overflow_q <= tx_val && !tx_rdy;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= head_dat;
`ifdef UART_TX_FIFO_PARITY_EN
            par_q   <= ^head_dat;
`endif
            baud_q  <= BIT_LAST;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            baud_q    <= BIT_LAST;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_FIFO_PARITY_EN
              baud_q  <= BIT_LAST;
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              baud_q  <= STOP_LAST;
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              baud_q    <= BIT_LAST;
              bit_idx_q <= bit_idx_q + IDX_ONE;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY: begin
          if (baud_q == '0) begin
            baud_q  <= STOP_LAST;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_q == '0) begin
            if (pop) begin
              shift_q <= head_dat;
`ifdef UART_TX_FIFO_PARITY_EN
              par_q   <= ^head_dat;
`endif
              baud_q  <= BIT_LAST;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 depth 16, 7-bit 2-stop depth 4) checked every cycle
// against a frame-level reference model, plus directed latency, burst, overflow and reset checks.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       val0, val1;
  logic [7:0] dat0;
  logic [6:0] dat1;
  logic       rdy0, tx0, busy0, ovf0;
  logic       rdy1, tx1, busy1, ovf1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst(rst), .tx_val(val0), .tx_data(dat0), .tx_rdy(rdy0),
    .tx(tx0), .busy(busy0), .fifo_count(cnt0), .overflow(ovf0));

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_val(val1), .tx_data(dat1), .tx_rdy(rdy1),
    .tx(tx1), .busy(busy1), .fifo_count(cnt1), .overflow(ovf1));

  int vec  = 0;
  int miss = 0;

  // Reference model: a word list per instance plus the frame currently on the line,
  // expressed as a bit vector and the number of clocks elapsed since its start bit began.
  int         dep [2] = '{16, 4};
  int         db  [2] = '{8, 7};
  int         sb  [2] = '{1, 2};
  logic [8:0] mq  [2][64];
  int         mh  [2], mt [2], mn [2];
  bit         act [2], movf [2];
  logic [15:0] fb [2];
  int         ft  [2], flen [2];

  task automatic model_edge(input int k, input bit v, input logic [8:0] w, input bit r);
    int c0;
    logic [8:0] hw;
    if (!r) begin
      mn[k] = 0; mh[k] = 0; mt[k] = 0; act[k] = 0; movf[k] = 0; ft[k] = 0;
      return;
    end
    c0 = mn[k];
    if (act[k]) begin
      ft[k]++;
      if (ft[k] == flen[k] * CPB) act[k] = 0;
    end
    if (!act[k] && c0 != 0) begin
      hw = mq[k][mh[k]];
      mh[k] = (mh[k] + 1) % 64;
      mn[k]--;
      fb[k] = '1;
      fb[k][0] = 1'b0;
      for (int i = 0; i < db[k]; i++) fb[k][1+i] = hw[i];
      if (PAR != 0) fb[k][1+db[k]] = ^hw;
      flen[k] = 1 + db[k] + PAR + sb[k];
      ft[k] = 0;
      act[k] = 1;
    end
    movf[k] = v && (c0 == dep[k]);
    if (v && c0 != dep[k]) begin
      mq[k][mt[k]] = w;
      mt[k] = (mt[k] + 1) % 64;
      mn[k]++;
    end
  endtask

  function automatic logic e_tx(input int k);
    return act[k] ? fb[k][ft[k] / CPB] : 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_tx",    32'(tx0),   32'(e_tx(0)));
    chk("a_busy",  32'(busy0), 32'(act[0] || mn[0] != 0));
    chk("a_rdy",   32'(rdy0),  32'(mn[0] != dep[0]));
    chk("a_count", 32'(cnt0),  32'(mn[0]));
    chk("a_ovf",   32'(ovf0),  32'(movf[0]));
    chk("b_tx",    32'(tx1),   32'(e_tx(1)));
    chk("b_busy",  32'(busy1), 32'(act[1] || mn[1] != 0));
    chk("b_rdy",   32'(rdy1),  32'(mn[1] != dep[1]));
    chk("b_count", 32'(cnt1),  32'(mn[1]));
    chk("b_ovf",   32'(ovf1),  32'(movf[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, val0, {1'b0, dat0}, rst);
    model_edge(1, val1, {2'b0, dat1}, rst);
    #1;
    check_all();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy0 || busy1) && n < budget) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(busy0 | busy1), 32'd0);
  endtask

  initial begin
    string msg = "Mikro-Tasarim";
    int    n, peak, pulses;
    bit    saw_low;

    rst = 1'b0; val0 = 1'b0; val1 = 1'b0; dat0 = '0; dat1 = '0;
    step(); step();
    chk("rst_tx",    32'(tx0),   32'd1);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_rdy",   32'(rdy0),  32'd1);
    chk("rst_count", 32'(cnt0),  32'd0);
    rst = 1'b1;
    step();

    // Single 8'h4D: busy must fall exactly one frame after the start bit.
    val0 = 1'b1; dat0 = 8'h4D;
    step();
    val0 = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (busy0 && n < 200);
    chk("a_single_busy_fall", 32'(n), 32'((10 + PAR) * CPB + 1));

    // Back-to-back burst of 13 characters into the 16-deep FIFO.
    for (int i = 0; i < msg.len(); i++) begin
      chk("a_burst_rdy", 32'(rdy0), 32'd1);
      val0 = 1'b1; dat0 = msg[i];
      step();
    end
    val0 = 1'b0;
    wait_idle(1000);

    // Six consecutive pushes into the 4-deep instance.
    peak = 0; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      val1 = (i < 6); dat1 = 7'(7'h11 + i);
      step();
      if (int'(cnt1) > peak) peak = int'(cnt1);
      pulses += int'(ovf1);
    end
    val1 = 1'b0;
    chk("b_ovf_peak", 32'(peak), 32'd4);
    chk("b_ovf_pulses", 32'(pulses), 32'd1);
    wait_idle(1000);

    // 7 data bits, 2 stop bits.
    val1 = 1'b1; dat1 = 7'h55;
    step();
    val1 = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (busy1 && n < 200);
    chk("b_sweep_busy_fall", 32'(n), 32'((10 + PAR) * CPB + 1));

    // Reset during data bit 3 with three words still queued.
    for (int i = 0; i < 4; i++) begin
      val0 = 1'b1; dat0 = 8'($urandom);
      step();
    end
    val0 = 1'b0;
    repeat (15) step();
    rst = 1'b0;
    step();
    chk("a_rst_mid_tx",    32'(tx0),   32'd1);
    chk("a_rst_mid_busy",  32'(busy0), 32'd0);
    chk("a_rst_mid_count", 32'(cnt0),  32'd0);
    rst = 1'b1;
    saw_low = 1'b0;
    repeat (60) begin
      step();
      if (tx0 !== 1'b1) saw_low = 1'b1;
    end
    chk("a_no_frame_after_rst", 32'(saw_low), 32'd0);

    // Random traffic on both instances, overflow included.
    for (int i = 0; i < 800; i++) begin
      val0 = ($urandom_range(0, 5) == 0); dat0 = 8'($urandom);
      val1 = ($urandom_range(0, 1) == 0); dat1 = 7'($urandom);
      step();
    end
    val0 = 1'b0; val1 = 1'b0;
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
